// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor
//   Sits on the pixel-clock side of the VGA output and checks the raw hs/vs
//   timing against the configured mode. It measures line length, frame length
//   and sync pulse widths. It also sums the active-region RGB of every frame,
//   so frames can be compared as one 32-bit signature.
//
//   Ports
//     pclk, rst        pixel clock; synchronous active-high reset
//     hs, vs           sync inputs under test (asserted level = SYNC_POL)
//     r, g, b          pixel colour, COLOR_W bits per channel
//     locked           mode has matched for at least one full frame
//     frame_done       one-cycle pulse when a good frame has been measured
//     frame_cnt        good frames since lock (the first locked frame reads 1)
//     checksum         active-region RGB sum of the frame reported by frame_done
//     h_meas, v_meas   last measured line length (pclk) and frame length (lines)
//     err_hsync        sticky horizontal timing error
//     err_vsync        sticky vertical timing error
//     dbg_state        current FSM state (SEEK=0, MEASURE=1, LOCKED=2)
module vga_frame_monitor #(
  parameter int H_TOTAL  = 1056,
  parameter int V_TOTAL  = 628,
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int HS_WIDTH = 128,
  parameter int VS_WIDTH = 4,
  parameter int H_BP     = 88,
  parameter int V_BP     = 23,
  parameter int COLOR_W  = 4,
  parameter int SYNC_POL = 1
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               hs,
  input  logic               vs,
  input  logic [COLOR_W-1:0] r,
  input  logic [COLOR_W-1:0] g,
  input  logic [COLOR_W-1:0] b,
  output logic               locked,
  output logic               frame_done,
  output logic [15:0]        frame_cnt,
  output logic [31:0]        checksum,
  output logic [15:0]        h_meas,
  output logic [15:0]        v_meas,
  output logic               err_hsync,
  output logic               err_vsync,
  output logic [1:0]         dbg_state
);

  localparam logic        SP        = (SYNC_POL != 0);
  localparam logic [15:0] H_TOT     = 16'(H_TOTAL);
  localparam logic [15:0] V_TOT     = 16'(V_TOTAL);
  localparam logic [15:0] HS_W      = 16'(HS_WIDTH);
  localparam logic [15:0] VS_W      = 16'(VS_WIDTH);
  localparam logic [15:0] H_ACT_LO  = 16'(HS_WIDTH + H_BP);
  localparam logic [15:0] H_ACT_HI  = 16'(HS_WIDTH + H_BP + H_ACTIVE - 1);
  localparam logic [15:0] V_ACT_LO  = 16'(VS_WIDTH + V_BP);
  localparam logic [15:0] V_ACT_HI  = 16'(VS_WIDTH + V_BP + V_ACTIVE - 1);
  localparam logic [15:0] STALL_CNT = 16'(2 * H_TOTAL);

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        hs_d, vs_d;
  logic        hs_on, vs_on, hle, hte, vle, vte;
  logic [15:0] hcnt, vcnt, hpw, vpw;
  logic [15:0] hcnt_inc, vcnt_inc;
  logic [31:0] acc;
  logic        active;
  logic        h_skip;      // ignore the first line measurement after entering MEASURE
  logic        frame_err;   // an error has been seen in the frame now being measured
  logic        check_en;
  logic        h_err_now, v_err_now, err_now;
  logic        done_now, enter_measure;

  assign hs_on = (hs == SP);
  assign vs_on = (vs == SP);
  assign hle   = hs_on && (hs_d != SP);
  assign hte   = !hs_on && (hs_d == SP);
  assign vle   = vs_on && (vs_d != SP);
  assign vte   = !vs_on && (vs_d == SP);

  assign hcnt_inc = hcnt + 16'd1;
  assign vcnt_inc = vcnt + 16'd1;

  assign active = (hcnt >= H_ACT_LO) && (hcnt <= H_ACT_HI) &&
                  (vcnt >= V_ACT_LO) && (vcnt <= V_ACT_HI);

  // Errors only count once the first vsync has given us a frame reference.
  assign check_en  = (state != SEEK);
  assign h_err_now = check_en &&
                     ((hle && !h_skip && (hcnt_inc != H_TOT)) ||
                      (hte && (hpw != HS_W)) ||
                      ((hcnt == STALL_CNT) && !hle));
  assign v_err_now = check_en &&
                     ((vle && (vcnt_inc != V_TOT)) ||
                      (vte && (vpw != VS_W)));
  assign err_now   = h_err_now || v_err_now;

  assign locked    = (state == LOCKED);
  assign dbg_state = state;

  always_ff @(posedge pclk) begin
    if (rst) state <= SEEK;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    done_now      = 1'b0;
    enter_measure = 1'b0;
    case (state)
      SEEK: begin
        if (vle) begin
          state_next    = MEASURE;
          enter_measure = 1'b1;
        end
      end
      MEASURE: begin
        // Errors inside the measured frame only decide the outcome at its end.
        if (vle) begin
          if (frame_err || err_now) begin
            state_next = SEEK;
          end else begin
            state_next = LOCKED;
            done_now   = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (err_now)  state_next = SEEK;
        else if (vle) done_now   = 1'b1;
      end
      default: state_next = SEEK;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hs_d       <= ~SP;
      vs_d       <= ~SP;
      hcnt       <= '0;
      vcnt       <= '0;
      hpw        <= '0;
      vpw        <= '0;
      acc        <= '0;
      h_skip     <= 1'b0;
      frame_err  <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      checksum   <= '0;
      h_meas     <= '0;
      v_meas     <= '0;
      err_hsync  <= 1'b0;
      err_vsync  <= 1'b0;
    end else begin
      hs_d <= hs;
      vs_d <= vs;

      if (hle)                   hcnt <= '0;
      else if (hcnt != 16'hFFFF) hcnt <= hcnt_inc;
      if (hle) h_meas <= hcnt_inc;

      // hle is itself the first asserted cycle of the pulse.
      if (hs_on) hpw <= hle ? 16'd1 : ((hpw == 16'hFFFF) ? hpw : hpw + 16'd1);

      if (vle)      vcnt <= '0;
      else if (hle) vcnt <= vcnt_inc;
      if (vle) v_meas <= vcnt_inc;

      // The line on which vs rises counts even if vle and hle do not coincide.
      if (vle)                vpw <= 16'd1;
      else if (vs_on && hle)  vpw <= vpw + 16'd1;

      if (vle)         acc <= '0;
      else if (active) acc <= acc + 32'({r, g, b});

      if (enter_measure) h_skip <= 1'b1;
      else if (hle)      h_skip <= 1'b0;

      if (vle)          frame_err <= 1'b0;
      else if (err_now) frame_err <= 1'b1;

      err_hsync  <= err_hsync | h_err_now;
      err_vsync  <= err_vsync | v_err_now;

      frame_done <= done_now;
      if (done_now) begin
        checksum  <= acc;
        frame_cnt <= (state == MEASURE) ? 16'd1 : frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Testbench for vga_frame_monitor using a reduced video mode
// (40x16 total, 20x8 active) so that each frame is 640 pixel clocks.
module tb_vga_frame_monitor;

  localparam int H_TOTAL  = 40;
  localparam int V_TOTAL  = 16;
  localparam int H_ACTIVE = 20;
  localparam int V_ACTIVE = 8;
  localparam int HS_WIDTH = 6;
  localparam int VS_WIDTH = 3;
  localparam int H_BP     = 5;
  localparam int V_BP     = 2;
  localparam int COLOR_W  = 4;
  localparam int SYNC_POL = 1;

  // Position in the driven line (p = 0 is the first hs cycle) of active column 0.
  // hcnt is cleared on the cycle after the hs leading edge, so it lags p by one.
  localparam int X0 = HS_WIDTH + H_BP + 1;
  localparam int Y0 = VS_WIDTH + V_BP;

  // clock / reset
  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  logic               hs = 1'b0, vs = 1'b0;
  logic [COLOR_W-1:0] r = '0, g = '0, b = '0;
  logic               locked, frame_done, err_hsync, err_vsync;
  logic [15:0]        frame_cnt, h_meas, v_meas;
  logic [31:0]        checksum;
  logic [1:0]         dbg_state;

  vga_frame_monitor #(
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
    .HS_WIDTH(HS_WIDTH), .VS_WIDTH(VS_WIDTH), .H_BP(H_BP), .V_BP(V_BP),
    .COLOR_W(COLOR_W), .SYNC_POL(SYNC_POL)
  ) dut (
    .pclk(pclk), .rst(rst), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .locked(locked), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .checksum(checksum), .h_meas(h_meas), .v_meas(v_meas),
    .err_hsync(err_hsync), .err_vsync(err_vsync), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard: {frame_cnt, checksum} expected at each frame_done
  logic [47:0] exp_q[$];
  logic [47:0] exp_e;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"},     locked,     0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_cnt"},  frame_cnt,  0);
    check({tag, "_checksum"},   checksum,   0);
    check({tag, "_h_meas"},     h_meas,     0);
    check({tag, "_v_meas"},     v_meas,     0);
    check({tag, "_err_hsync"},  err_hsync,  0);
    check({tag, "_err_vsync"},  err_vsync,  0);
  endtask

  // One record per driven frame. done_cnt = 0 means no frame_done is
  // expected at the vsync that ends this frame. end_* are sampled on the
  // last cycle of the frame, before the next vsync.
  typedef struct {
    int          mode;          // 0: all 0xFFF, 1: two 0x111 corners, 2: r=x g=y
    int          stretch_line;  // line lengthened by one cycle, -1 none
    int          vs_lines;      // vsync width in lines
    int          rst_line;      // line with a one-cycle reset at p=5, -1 none
    logic [15:0] done_cnt;
    logic [31:0] done_sum;
    logic        end_locked;
    logic [15:0] end_cnt;
    logic        end_eh;
    logic        end_ev;
  } frame_vec_t;

  frame_vec_t vecs [0:11];

  function automatic logic [11:0] pixel(input int mode, input int x, input int y);
    case (mode)
      0:       return 12'hFFF;
      1:       return (((x == 0) && (y == 0)) || ((x == H_ACTIVE-1) && (y == V_ACTIVE-1)))
                      ? 12'h111 : 12'h000;
      default: return {4'(x), 4'(y), 4'h0};
    endcase
  endfunction

  // driver tasks
  task automatic drive_cycle(input logic h, input logic v, input logic [11:0] rgb);
    hs = h;
    vs = v;
    {r, g, b} = rgb;
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_frame(input frame_vec_t fv);
    for (int l = 0; l < V_TOTAL; l++) begin
      int len;
      len = (l == fv.stretch_line) ? H_TOTAL + 1 : H_TOTAL;
      for (int p = 0; p < len; p++) begin
        int x, y;
        logic [11:0] rgb;
        x = p - X0;
        y = l - Y0;
        if (x >= 0 && x < H_ACTIVE && y >= 0 && y < V_ACTIVE)
          rgb = pixel(fv.mode, x, y);
        else
          rgb = 12'($urandom);   // outside the active window must not count
        if (l == fv.rst_line && p == 5) begin
          check("locked_before_rst", locked, 1);
          rst = 1'b1;
          drive_cycle(p < HS_WIDTH, l < fv.vs_lines, rgb);
          rst = 1'b0;
          check_all_zero("mid_rst");
        end else begin
          drive_cycle(p < HS_WIDTH, l < fv.vs_lines, rgb);
        end
        if (l == fv.stretch_line && p == len - 1) begin
          check("stretch_err_before_hle", err_hsync, 0);
          check("stretch_locked_before_hle", locked, 1);
        end
        if (l == fv.stretch_line + 1 && p == 0 && fv.stretch_line >= 0) begin
          check("stretch_err_at_hle", err_hsync, 1);
          check("stretch_locked_at_hle", locked, 0);
        end
      end
    end
    check("end_locked",    locked,    fv.end_locked);
    check("end_frame_cnt", frame_cnt, fv.end_cnt);
    check("end_err_hsync", err_hsync, fv.end_eh);
    check("end_err_vsync", err_vsync, fv.end_ev);
    check("end_h_meas",    h_meas,    H_TOTAL);
    if (fv.done_cnt != 0) exp_q.push_back({fv.done_cnt, fv.done_sum});
  endtask

  // frame_done monitor, sampled on the falling edge
  always @(negedge pclk) begin
    if (!rst && frame_done) begin
      check("done_one_cycle", prev_done, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got frame_done=1 frame_cnt=%0d expected no pulse", frame_cnt);
      end else begin
        exp_e = exp_q.pop_front();
        check("checksum",       checksum,  exp_e[31:0]);
        check("done_frame_cnt", frame_cnt, exp_e[47:32]);
        check("locked_at_done", locked,    1);
        check("v_meas",         v_meas,    V_TOTAL);
        check("h_meas",         h_meas,    H_TOTAL);
      end
    end
    prev_done = frame_done;
  end

  initial begin
    //             mode strl vsl rstl cnt  sum           lock cnt   eh    ev
    vecs[0]  = '{0, -1, 3, -1, 16'd1, 32'h0009FF60, 1'b0, 16'd0, 1'b0, 1'b0};
    vecs[1]  = '{0, -1, 3, -1, 16'd2, 32'h0009FF60, 1'b1, 16'd1, 1'b0, 1'b0};
    vecs[2]  = '{1, -1, 3, -1, 16'd3, 32'h00000222, 1'b1, 16'd2, 1'b0, 1'b0};
    vecs[3]  = '{2, -1, 3, -1, 16'd4, 32'h00041300, 1'b1, 16'd3, 1'b0, 1'b0};
    vecs[4]  = '{0,  7, 3, -1, 16'd0, 32'h00000000, 1'b0, 16'd4, 1'b1, 1'b0};
    vecs[5]  = '{0, -1, 3, -1, 16'd1, 32'h0009FF60, 1'b0, 16'd4, 1'b1, 1'b0};
    vecs[6]  = '{1, -1, 3, -1, 16'd2, 32'h00000222, 1'b1, 16'd1, 1'b1, 1'b0};
    vecs[7]  = '{0, -1, 2, -1, 16'd0, 32'h00000000, 1'b0, 16'd2, 1'b1, 1'b1};
    vecs[8]  = '{2, -1, 3, -1, 16'd1, 32'h00041300, 1'b0, 16'd2, 1'b1, 1'b1};
    vecs[9]  = '{0, -1, 3,  6, 16'd0, 32'h00000000, 1'b0, 16'd0, 1'b0, 1'b0};
    vecs[10] = '{0, -1, 3, -1, 16'd1, 32'h0009FF60, 1'b0, 16'd0, 1'b0, 1'b0};
    vecs[11] = '{1, -1, 3, -1, 16'd2, 32'h00000222, 1'b1, 16'd1, 1'b0, 1'b0};

    rst = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 12; i++) drive_frame(vecs[i]);

    // Stall: a vsync/hsync start, then hs stays low. hcnt equals k after
    // the k-th edge, so the timeout becomes visible after edge 2*H_TOTAL+1.
    check("stall_err_before", err_hsync, 0);
    for (int k = 0; k < 2*H_TOTAL + 8; k++) begin
      drive_cycle(k < HS_WIDTH, 1'b1, 12'h000);
      if (k == 2*H_TOTAL) begin
        check("stall_err_edge_minus1", err_hsync, 0);
        check("stall_locked_minus1",   locked,    1);
      end
      if (k == 2*H_TOTAL + 1) begin
        check("stall_err_edge",    err_hsync, 1);
        check("stall_locked_drop", locked,    0);
      end
    end
    check("stall_frame_cnt", frame_cnt, 2);
    check("stall_err_vsync", err_vsync, 0);

    repeat (4) drive_cycle(1'b0, 1'b0, 12'h000);
    check("pending_done", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
